// File: rtl/sram_arb_pkg.sv
// Shared types for the two-requester SRAM arbiter: response FSM states and
// requester ids used by the round-robin pointer.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } resp_state_t;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

endpackage

// File: rtl/sram_arb_grant.sv
// Grant selection between the inst and data requesters. Default build: data
// priority with an inst starvation override; ARB_ROUND_ROBIN_EN: round-robin.
module sram_arb_grant
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic inst_req,
  input  logic data_req,
  output logic grant_inst,
  output logic grant_data
);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_winner;

  // NOTE: grants are gated by resetn so no request can leak onto the SRAM
  // while reset is held, even though the reset itself is synchronous.
  always_comb begin
    grant_inst = resetn && inst_req && (!data_req || last_winner == ID_DATA);
    grant_data = resetn && data_req && !grant_inst;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn)         last_winner <= ID_DATA;
    else if (grant_inst) last_winner <= ID_INST;
    else if (grant_data) last_winner <= ID_DATA;
  end
`else
  logic [3:0] wait_cnt;
  logic       starved;

  assign starved = wait_cnt >= 4'(STARVE_LIMIT);

  // NOTE: grants are gated by resetn so no request can leak onto the SRAM
  // while reset is held, even though the reset itself is synchronous.
  always_comb begin
    grant_inst = resetn && inst_req && (!data_req || starved);
    grant_data = resetn && data_req && !grant_inst;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!resetn || !inst_req || grant_inst) wait_cnt <= '0;
    else if (wait_cnt != 4'hF)              wait_cnt <= wait_cnt + 4'd1;
  end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Two-port (inst/data) arbiter onto one single-cycle SRAM, with a response
// FSM returning data_ok one cycle after addr_ok. Option: ARB_ROUND_ROBIN_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  inst_req,
  input  logic [DATA_W/8-1:0]   inst_wen,
  input  logic [ADDR_W-1:0]     inst_addr,
  input  logic [DATA_W-1:0]     inst_wdata,
  output logic                  inst_addr_ok,
  output logic                  inst_data_ok,
  output logic [DATA_W-1:0]     inst_rdata,
  input  logic                  data_req,
  input  logic [DATA_W/8-1:0]   data_wen,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_wdata,
  output logic                  data_addr_ok,
  output logic                  data_data_ok,
  output logic [DATA_W-1:0]     data_rdata,
  output logic                  sram_en,
  output logic [DATA_W/8-1:0]   sram_wen,
  output logic [ADDR_W-1:0]     sram_addr,
  output logic [DATA_W-1:0]     sram_wdata,
  input  logic [DATA_W-1:0]     sram_rdata
);

  logic        grant_inst;
  logic        grant_data;
  resp_state_t state;

  sram_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk),
    .resetn    (resetn),
    .inst_req  (inst_req),
    .data_req  (data_req),
    .grant_inst(grant_inst),
    .grant_data(grant_data)
  );

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign sram_en      = grant_inst | grant_data;

  // NOTE: every output of this block gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (grant_data) begin
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (grant_inst) begin
      sram_wen   = inst_wen;
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
    end
  end

  // The next state depends only on this cycle's grant, so back-to-back
  // grants simply chain responses with no idle cycle between them.
  always_ff @(posedge clk) begin
    if (!resetn)         state <= IDLE;
    else if (grant_inst) state <= RESP_I;
    else if (grant_data) state <= RESP_D;
    else                 state <= IDLE;
  end

  // resetn gating drops a pending response in the very cycle reset appears.
  assign inst_data_ok = resetn && (state == RESP_I);
  assign data_data_ok = resetn && (state == RESP_D);
  assign inst_rdata   = inst_data_ok ? sram_rdata : '0;
  assign data_rdata   = data_data_ok ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them against data_ok.
module tb_sram_arbiter;

  localparam int W_NONE = 0;
  localparam int W_INST = 1;
  localparam int W_DATA = 2;

  typedef struct packed {
    logic        req;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } port_t;

  typedef struct packed {
    logic        is_data;
    logic        is_read;
    logic [31:0] rdata;
    logic [31:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, data_req;
  logic [3:0]  inst_wen, data_wen, sram_wen;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, sram_en;
  logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] cyc   = 32'h0;
  exp_t        sb[$];

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wen(inst_wen), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // SRAM model: fixed read contents, data one cycle after the enable.
  function automatic logic [31:0] sram_val(input logic [31:0] a);
    case (a)
      32'h0000_0100: sram_val = 32'hDEAD_BEEF;
      32'h0000_0200: sram_val = 32'h0BAD_F00D;
      32'h0000_0300: sram_val = 32'h1234_5678;
      default:       sram_val = 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (sram_en) sram_rdata <= (sram_wen != 4'b0) ? 32'hFFFF_FFFF : sram_val(sram_addr);
    else         sram_rdata <= 32'h0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every data_ok must match the oldest expected response, in the
  // exact cycle after its grant; idle rdata must read zero.
  always @(negedge clk) begin
    exp_t e;
    if (inst_data_ok && data_data_ok) check("both_data_ok", 64'(1), 64'(0));
    if (!inst_data_ok) check("inst_rdata_idle_zero", 64'(inst_rdata), 64'(0));
    if (!data_data_ok) check("data_rdata_idle_zero", 64'(data_rdata), 64'(0));
    if (inst_data_ok || data_data_ok) begin
      if (sb.size() == 0) begin
        check("unexpected_data_ok", {62'b0, inst_data_ok, data_data_ok}, 64'(0));
      end else begin
        e = sb.pop_front();
        check("resp_port", 64'(data_data_ok), 64'(e.is_data));
        check("resp_cycle", 64'(cyc), 64'(e.cyc));
        if (e.is_read)
          check("resp_rdata", 64'(e.is_data ? data_rdata : inst_rdata), 64'(e.rdata));
      end
    end
  end

  // Drive one cycle (entered #1 after posedge), check grants and the SRAM
  // bus at negedge, and queue the expected response for the monitor.
  task automatic step(input port_t pi, input port_t pd, input int win,
                      input logic [31:0] exp_rd, input bit push);
    port_t w;
    inst_req = pi.req; inst_wen = pi.wen; inst_addr = pi.addr; inst_wdata = pi.wdata;
    data_req = pd.req; data_wen = pd.wen; data_addr = pd.addr; data_wdata = pd.wdata;
    w = (win == W_INST) ? pi : (win == W_DATA) ? pd : '0;
    @(negedge clk);
    check("inst_addr_ok", 64'(inst_addr_ok), 64'(win == W_INST));
    check("data_addr_ok", 64'(data_addr_ok), 64'(win == W_DATA));
    check("sram_en", 64'(sram_en), 64'(win != W_NONE));
    check("sram_wen", 64'(sram_wen), 64'(w.wen));
    check("sram_addr", 64'(sram_addr), 64'(w.addr));
    check("sram_wdata", 64'(sram_wdata), 64'(w.wdata));
    if (!resetn) begin
      check("reset_inst_data_ok", 64'(inst_data_ok), 64'(0));
      check("reset_data_data_ok", 64'(data_data_ok), 64'(0));
    end
    if (push && win != W_NONE)
      sb.push_back('{is_data: (win == W_DATA), is_read: (w.wen == 4'b0),
                     rdata: exp_rd, cyc: cyc + 32'd1});
    @(posedge clk);
    #1;
  endtask

  localparam port_t P_IDLE  = '{req: 1'b0, wen: 4'b0,    addr: 32'h0,      wdata: 32'h0};
  localparam port_t I_RD100 = '{req: 1'b1, wen: 4'b0,    addr: 32'h100,    wdata: 32'h0};
  localparam port_t I_RD200 = '{req: 1'b1, wen: 4'b0,    addr: 32'h200,    wdata: 32'h0};
  localparam port_t D_RD300 = '{req: 1'b1, wen: 4'b0,    addr: 32'h300,    wdata: 32'h0};
  localparam port_t D_WR    = '{req: 1'b1, wen: 4'b0011, addr: 32'h2000,   wdata: 32'h1234};

  initial begin
    int win;
    resetn = 1'b0;
    inst_req = 1'b0; inst_wen = 4'b0; inst_addr = 32'h0; inst_wdata = 32'h0;
    data_req = 1'b0; data_wen = 4'b0; data_addr = 32'h0; data_wdata = 32'h0;
    @(posedge clk);
    #1;

    // Reset: outputs quiet even with both requesters asserting.
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);
    step(I_RD100, D_RD300, W_NONE, 32'h0, 1'b1);

    // Contention starting in the first cycle out of reset.
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      win = (k % 2 == 0) ? W_INST : W_DATA;
`else
      win = (k % 5 == 4) ? W_INST : W_DATA;
`endif
      step(I_RD100, D_RD300, win, (win == W_INST) ? 32'hDEAD_BEEF : 32'h1234_5678, 1'b1);
    end
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);

    // Single inst read, then a byte-masked data write.
    step(I_RD100, P_IDLE, W_INST, 32'hDEAD_BEEF, 1'b1);
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);
    step(P_IDLE, D_WR, W_DATA, 32'h0, 1'b1);
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);

    // Back-to-back: inst then data on consecutive cycles.
    step(I_RD200, P_IDLE, W_INST, 32'h0BAD_F00D, 1'b1);
    step(P_IDLE, D_RD300, W_DATA, 32'h1234_5678, 1'b1);
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);

    // Reset mid-op: the granted response must never appear.
    step(I_RD100, P_IDLE, W_INST, 32'h0, 1'b0);
    resetn = 1'b0;
    step(I_RD100, P_IDLE, W_NONE, 32'h0, 1'b1);
    resetn = 1'b1;
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);

    // Fresh request right after the mid-op reset.
    step(P_IDLE, D_RD300, W_DATA, 32'h1234_5678, 1'b1);
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);
    step(P_IDLE, P_IDLE, W_NONE, 32'h0, 1'b1);

    check("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, requester and SRAM address width.
REQ-002 Parameter DATA_W, default 32, data width; byte-write width is DATA_W/8.
REQ-003 Parameter STARVE_LIMIT, default 4, consecutive denied inst cycles before a forced inst grant; legal range 1..15.
REQ-004 The block SHALL use one clock, clk; reset is resetn, synchronous, active-low.
REQ-005 Ports, in this order:
- clk in 1: clock.
- resetn in 1: synchronous active-low reset.
- inst_req in 1: inst request.
- inst_wen in DATA_W/8: inst byte writes; 0 means read.
- inst_addr in ADDR_W: inst address.
- inst_wdata in DATA_W: inst write data.
- inst_addr_ok out 1: inst request accepted this cycle.
- inst_data_ok out 1: inst response valid.
- inst_rdata out DATA_W: inst read data.
- data_req, data_wen, data_addr, data_wdata, data_addr_ok, data_data_ok, data_rdata: the same set for the data requester.
- sram_en out 1: shared SRAM enable.
- sram_wen out DATA_W/8: shared SRAM byte writes.
- sram_addr out ADDR_W: shared SRAM address.
- sram_wdata out DATA_W: shared SRAM write data.
- sram_rdata in DATA_W: shared SRAM read data, valid 1 cycle after sram_en.

Function
REQ-006 The SHALL-grant choice is combinational each cycle: at most one of inst_addr_ok/data_addr_ok is high, and only when the matching req is high.
REQ-007 sram_en SHALL equal (inst_addr_ok | data_addr_ok); sram_wen/addr/wdata SHALL be the winner's inputs, else all zero.
REQ-008 Default priority: data beats inst when both request.
REQ-009 A 4-bit counter wait_cnt SHALL increment (saturating at 15) each cycle inst_req is high and not granted, and clear on an inst grant or when inst_req is low.
REQ-010 When wait_cnt >= STARVE_LIMIT and inst_req is high, inst SHALL win over data for that cycle.
REQ-011 The response FSM has states IDLE, RESP_I and RESP_D; the next state is RESP_I on an inst grant, RESP_D on a data grant, else IDLE; it moves from any state, so back-to-back grants are allowed.
REQ-012 In RESP_I the block SHALL drive inst_data_ok=1 and inst_rdata=sram_rdata; RESP_D does the same for the data port; the other port's data_ok is 0.
REQ-013 Response latency SHALL be exactly 1 cycle after addr_ok, for reads and writes alike; a write response's rdata is don't-care.
REQ-014 Requesters hold req/wen/addr/wdata stable until addr_ok; the arbiter carries no request buffering.
REQ-015 rdata outputs SHALL be zero when their data_ok is low.

Reset
REQ-016 While resetn=0: all addr_ok, data_ok and sram_en are 0; sram_wen/addr/wdata are 0; the FSM is IDLE; wait_cnt is 0.
REQ-017 Reset asserted with a response pending SHALL drop it, with no data_ok in the cycle after reset release.
REQ-018 A grant is legal in the first cycle with resetn=1.

Configuration
REQ-019 With ARB_ROUND_ROBIN_EN defined, the block SHALL replace REQ-008..REQ-010 with round-robin on contention: a 1-bit last-winner register, reset value data, makes the port not last granted win.
REQ-020 With ARB_ROUND_ROBIN_EN defined, wait_cnt and STARVE_LIMIT are unused.
REQ-021 Without ARB_ROUND_ROBIN_EN, the block uses fixed data priority with the starvation override.

Structure
REQ-022 Package sram_arb_pkg SHALL hold the FSM state enum (IDLE, RESP_I, RESP_D) and the requester-id constants ID_INST=0, ID_DATA=1.
REQ-023 The grant logic SHALL be one sub-module, sram_arb_grant, holding the priority, wait counter and round-robin pointer; the top holds the FSM and muxes.

Verification
REQ-024 Single inst read: inst_req=1, addr=0x100, sram_rdata=0xDEADBEEF next cycle -> inst_addr_ok=1 at cycle 0, inst_data_ok=1 and inst_rdata=0xDEADBEEF at cycle 1.
REQ-025 Contention without the macro: both req=1 continuously -> data wins at cycles 0-3, inst wins at cycle 4 (STARVE_LIMIT=4), data wins at cycles 5-8, and the pattern repeats.
REQ-026 Round robin (macro defined): both req=1 continuously -> grants alternate inst, data, inst, ... starting with inst after reset.
REQ-027 Data write: data_req=1, data_wen=4'b0011, data_addr=0x2000, data_wdata=0x1234 -> same cycle sram_en=1, sram_wen=4'b0011, sram_addr=0x2000, sram_wdata=0x1234; data_data_ok=1 next cycle.
REQ-028 Back-to-back: inst read at cycle 0, data read at cycle 1 -> inst_data_ok at cycle 1 and data_data_ok at cycle 2, never both in one cycle.
REQ-029 Reset mid-op: grant at cycle 0, resetn=0 at cycle 1, released at cycle 2 -> no data_ok at cycles 1-2 and all outputs 0 during reset.
